// File: rtl/nonoverlap_clk_monitor_if.sv
// Signal bundle between the clock-pad return path and the modulation clock monitor.
// master drives the observed clocks and CLR_ERR; slave is the monitor itself.
`timescale 1ns/1ps
interface nonoverlap_clk_monitor_if;
    logic       MOD_IN;
    logic       MODN_IN;
    logic       MODL_IN;
    logic       CLR_ERR;
    logic [4:0] MEAS_PHASE;
    logic [3:0] MEAS_DUTY;
    // MEAS_VALID qualifies MEAS_PHASE/MEAS_DUTY for one cycle with no back-pressure;
    // both values hold their last published contents between pulses.
    logic       MEAS_VALID;
    logic       LOCKED;
    logic       FRAME_ERR;
    logic       OVERLAP_ERR;
    logic       PAIR_ERR;

    modport master (
        output MOD_IN, MODN_IN, MODL_IN, CLR_ERR,
        input  MEAS_PHASE, MEAS_DUTY, MEAS_VALID, LOCKED, FRAME_ERR, OVERLAP_ERR, PAIR_ERR
    );

    modport slave (
        input  MOD_IN, MODN_IN, MODL_IN, CLR_ERR,
        output MEAS_PHASE, MEAS_DUTY, MEAS_VALID, LOCKED, FRAME_ERR, OVERLAP_ERR, PAIR_ERR
    );
endinterface

// File: rtl/nonoverlap_clk_monitor.sv
// Samples MOD/MODN/MODL on the system clock, decodes phase and duty of MOD,
// checks frame length, MOD/MODN pairing and non-overlap, and tracks lock.
`timescale 1ns/1ps
module nonoverlap_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FRAMES = 2
) (
    input logic                     CLK_IN,
    input logic                     RST_N,
    nonoverlap_clk_monitor_if.slave bus
);

    localparam logic [3:0] LOCK_TH = 4'(LOCK_FRAMES);

    logic [SYNC_STAGES-1:0] sync_mod, sync_modn, sync_modl;
    logic s_mod, s_modn, s_modl;
    logic d_mod, d_modn, d_modl;
    logic mod_rise, mod_fall, modn_rise, modn_fall, modl_rise;

    logic [5:0] pos, cur_pos, hi_cnt;
    logic       first;

    logic [4:0] wcnt, wcnt_n, width_mod, width_modn;
    logic [1:0] rise_cnt, rise_cnt_n;
    logic [4:0] rise_pos, rise_pos_n;
    logic [3:0] cand_duty, cand_duty_eff;
    logic [4:0] cand_phase, cand_phase_n, w_mod_eff, w_modn_eff;

    logic       frame_chk, ovl_evt, frame_evt, pair_evt, any_evt;
    logic       mod_long, modn_long, pair_rise_bad, frame_bad, frame_bad_eff, same;
    logic [3:0] lock_cnt;
    logic [4:0] meas_phase;
    logic [3:0] meas_duty;
    logic       meas_valid, frame_err, overlap_err, pair_err;

    assign s_mod  = sync_mod[SYNC_STAGES-1];
    assign s_modn = sync_modn[SYNC_STAGES-1];
    assign s_modl = sync_modl[SYNC_STAGES-1];

    assign mod_rise  = s_mod & ~d_mod;
    assign mod_fall  = ~s_mod & d_mod;
    assign modn_rise = s_modn & ~d_modn;
    assign modn_fall = ~s_modn & d_modn;
    assign modl_rise = s_modl & ~d_modl;

    // Equal synchronizer depth on all three inputs keeps their relative timing.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync_mod  <= '0;
            sync_modn <= '0;
            sync_modl <= '0;
            d_mod     <= 1'b0;
            d_modn    <= 1'b0;
            d_modl    <= 1'b0;
        end else begin
            sync_mod[0]  <= bus.MOD_IN;
            sync_modn[0] <= bus.MODN_IN;
            sync_modl[0] <= bus.MODL_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_mod[i]  <= sync_mod[i-1];
                sync_modn[i] <= sync_modn[i-1];
                sync_modl[i] <= sync_modl[i-1];
            end
            d_mod  <= s_mod;
            d_modn <= s_modn;
            d_modl <= s_modl;
        end
    end

    // Position of the current sample within the frame; the MODL rise sample is 0.
    assign cur_pos = modl_rise ? 6'd0 : ((pos == 6'd63) ? 6'd63 : pos + 6'd1);

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            pos    <= 6'd0;
            hi_cnt <= 6'd0;
            first  <= 1'b1;
        end else begin
            pos <= cur_pos;
            if (modl_rise) begin
                hi_cnt <= 6'd1;
                first  <= 1'b0;
            end else if (s_modl && hi_cnt != 6'd63) begin
                hi_cnt <= hi_cnt + 6'd1;
            end
        end
    end

    // Width counters run across frame boundaries so straddling pulses measure whole.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            wcnt       <= 5'd0;
            wcnt_n     <= 5'd0;
            width_mod  <= 5'd0;
            width_modn <= 5'd0;
            cand_duty  <= 4'd0;
            rise_cnt   <= 2'd0;
            rise_cnt_n <= 2'd0;
            rise_pos   <= 5'd0;
            rise_pos_n <= 5'd0;
        end else begin
            if (s_mod) wcnt <= (wcnt == 5'd31) ? 5'd31 : wcnt + 5'd1;
            else       wcnt <= 5'd0;
            if (s_modn) wcnt_n <= (wcnt_n == 5'd31) ? 5'd31 : wcnt_n + 5'd1;
            else        wcnt_n <= 5'd0;

            if (mod_fall) begin
                width_mod <= wcnt;
                if (wcnt <= 5'd16) cand_duty <= wcnt[3:0] - 4'd1;
            end
            if (modn_fall) width_modn <= wcnt_n;

            if (mod_rise)  rise_pos   <= cur_pos[4:0];
            if (modn_rise) rise_pos_n <= cur_pos[4:0];

            // A rise on the MODL rise sample belongs to the frame that starts there.
            if (modl_rise) begin
                rise_cnt   <= {1'b0, mod_rise};
                rise_cnt_n <= {1'b0, modn_rise};
            end else begin
                if (mod_rise && rise_cnt != 2'd2)    rise_cnt   <= rise_cnt + 2'd1;
                if (modn_rise && rise_cnt_n != 2'd2) rise_cnt_n <= rise_cnt_n + 2'd1;
            end
        end
    end

    assign cand_phase    = 5'd31 - rise_pos;
    assign cand_phase_n  = 5'd31 - rise_pos_n;
    assign w_mod_eff     = mod_fall ? wcnt : width_mod;
    assign w_modn_eff    = modn_fall ? wcnt_n : width_modn;
    assign cand_duty_eff = (mod_fall && wcnt <= 5'd16) ? (wcnt[3:0] - 4'd1) : cand_duty;

    assign frame_chk     = modl_rise & ~first;
    assign ovl_evt       = s_mod & s_modn;
    assign frame_evt     = frame_chk && (pos != 6'd31 || hi_cnt != 6'd16);
    assign mod_long      = (s_mod && wcnt == 5'd16) || (mod_fall && wcnt > 5'd16);
    assign modn_long     = (s_modn && wcnt_n == 5'd16) || (modn_fall && wcnt_n > 5'd16);
    assign pair_rise_bad = (rise_cnt != 2'd1) || (rise_cnt_n != 2'd1) ||
                           (cand_phase_n != cand_phase - 5'd16) || (w_mod_eff != w_modn_eff);
    assign pair_evt      = (frame_chk && pair_rise_bad) || mod_long || modn_long;
    assign any_evt       = ovl_evt | frame_evt | pair_evt;
    assign frame_bad_eff = frame_bad | any_evt;
    assign same          = (cand_phase == meas_phase) && (cand_duty_eff == meas_duty);

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            meas_phase  <= 5'd0;
            meas_duty   <= 4'd0;
            meas_valid  <= 1'b0;
            lock_cnt    <= 4'd0;
            frame_bad   <= 1'b0;
            frame_err   <= 1'b0;
            overlap_err <= 1'b0;
            pair_err    <= 1'b0;
        end else begin
            meas_valid <= frame_chk;
            if (frame_chk) begin
                meas_phase <= cand_phase;
                meas_duty  <= cand_duty_eff;
            end

            if (modl_rise) frame_bad <= 1'b0;
            else           frame_bad <= frame_bad_eff;

            if (frame_chk) begin
                if (!frame_bad_eff && same) lock_cnt <= (lock_cnt == 4'd15) ? 4'd15 : lock_cnt + 4'd1;
                else                        lock_cnt <= 4'd0;
            end else if (any_evt) begin
                lock_cnt <= 4'd0;
            end

            // A new event in the same cycle as CLR_ERR keeps the flag set.
            if (frame_evt)         frame_err <= 1'b1;
            else if (bus.CLR_ERR)  frame_err <= 1'b0;
            if (ovl_evt)           overlap_err <= 1'b1;
            else if (bus.CLR_ERR)  overlap_err <= 1'b0;
            if (pair_evt)          pair_err <= 1'b1;
            else if (bus.CLR_ERR)  pair_err <= 1'b0;
        end
    end

    assign bus.MEAS_PHASE  = meas_phase;
    assign bus.MEAS_DUTY   = meas_duty;
    assign bus.MEAS_VALID  = meas_valid;
    assign bus.LOCKED      = (lock_cnt >= LOCK_TH);
    assign bus.FRAME_ERR   = frame_err;
    assign bus.OVERLAP_ERR = overlap_err;
    assign bus.PAIR_ERR    = pair_err;

endmodule

// File: tb/tb_nonoverlap_clk_monitor.sv
// Directed bench: a frame-accurate model of the clock generator drives the monitor,
// outputs are checked mid-frame against hand-derived values.
`timescale 1ns/1ps
module tb_nonoverlap_clk_monitor;

    logic clk;
    logic rst_n;
    nonoverlap_clk_monitor_if bus();

    nonoverlap_clk_monitor #(.SYNC_STAGES(2), .LOCK_FRAMES(2)) dut (
        .CLK_IN (clk),
        .RST_N  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int c;
    int flen;
    int phase_sel;
    int duty_sel;
    bit glitch;
    bit modl_off;
    int valid_cnt = 0;
    int vc0;
    int total = 0;
    int bad = 0;

    always @(negedge clk) if (bus.MEAS_VALID === 1'b1) valid_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One generator cycle: frame position c, MOD rise at 31-PHASE_SEL, width DUTY_SEL+1.
    task automatic step();
        int p, t, tn;
        @(negedge clk);
        p  = (31 - phase_sel) & 31;
        t  = (c - p) & 31;
        tn = (c - p - 16) & 31;
        bus.MODL_IN = !modl_off && (c < 16);
        bus.MOD_IN  = (t <= duty_sel);
        bus.MODN_IN = (tn <= duty_sel) || (glitch && c == 12);
        c = c + 1;
        if (c >= flen) begin
            c = 0;
            flen = 32;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Release reset while MODL is low so the first seen MODL rise starts a full frame.
    task automatic do_release();
        run(2);
        while (c != 20) run(1);
        rst_n = 1'b1;
        while (c != 0) run(1);
    endtask

    initial begin
        bus.MOD_IN = 1'b0; bus.MODN_IN = 1'b0; bus.MODL_IN = 1'b0; bus.CLR_ERR = 1'b0;
        rst_n = 1'b0;
        c = 0; flen = 32; phase_sel = 20; duty_sel = 3; glitch = 1'b0; modl_off = 1'b0;

        run(3);
        chk("rst_phase",   32'(bus.MEAS_PHASE), 0);
        chk("rst_duty",    32'(bus.MEAS_DUTY), 0);
        chk("rst_valid",   32'(bus.MEAS_VALID), 0);
        chk("rst_locked",  32'(bus.LOCKED), 0);
        chk("rst_frame",   32'(bus.FRAME_ERR), 0);
        chk("rst_overlap", 32'(bus.OVERLAP_ERR), 0);
        chk("rst_pair",    32'(bus.PAIR_ERR), 0);

        // Phase 20, duty 3
        do_release();
        vc0 = valid_cnt;
        run(16);
        chk("p20_no_first_pub", 32'(valid_cnt - vc0), 0);
        run(32);
        chk("p20_phase",   32'(bus.MEAS_PHASE), 20);
        chk("p20_duty",    32'(bus.MEAS_DUTY), 3);
        chk("p20_pub1",    32'(valid_cnt - vc0), 1);
        chk("p20_lock_p1", 32'(bus.LOCKED), 0);
        chk("p20_frame",   32'(bus.FRAME_ERR), 0);
        chk("p20_pair",    32'(bus.PAIR_ERR), 0);
        chk("p20_overlap", 32'(bus.OVERLAP_ERR), 0);
        run(32);
        chk("p20_lock_p2", 32'(bus.LOCKED), 0);
        run(32);
        chk("p20_lock_p3", 32'(bus.LOCKED), 1);

        // MODN forced high for one sample inside the MOD pulse
        run(16);
        glitch = 1'b1;
        run(13);
        run(2);
        chk("ovl_before",      32'(bus.OVERLAP_ERR), 0);
        chk("ovl_lock_before", 32'(bus.LOCKED), 1);
        run(1);
        chk("ovl_set",         32'(bus.OVERLAP_ERR), 1);
        chk("ovl_lock_drop",   32'(bus.LOCKED), 0);
        glitch = 1'b0;
        run(32);
        chk("ovl_pair_extra_rise", 32'(bus.PAIR_ERR), 1);
        bus.CLR_ERR = 1'b1;
        run(1);
        bus.CLR_ERR = 1'b0;
        run(1);
        chk("clr_overlap", 32'(bus.OVERLAP_ERR), 0);
        chk("clr_pair",    32'(bus.PAIR_ERR), 0);
        chk("clr_locked",  32'(bus.LOCKED), 0);
        run(30);
        chk("relock_1", 32'(bus.LOCKED), 0);
        run(32);
        chk("relock_2", 32'(bus.LOCKED), 1);

        // One 33-cycle MODL period
        flen = 33;
        run(17);
        run(16);
        chk("stretch_frame",  32'(bus.FRAME_ERR), 1);
        chk("stretch_locked", 32'(bus.LOCKED), 0);
        chk("stretch_phase",  32'(bus.MEAS_PHASE), 20);
        run(32);
        chk("stretch_next_phase", 32'(bus.MEAS_PHASE), 20);
        chk("stretch_next_duty",  32'(bus.MEAS_DUTY), 3);
        chk("stretch_sticky",     32'(bus.FRAME_ERR), 1);
        bus.CLR_ERR = 1'b1;
        run(1);
        bus.CLR_ERR = 1'b0;
        run(1);
        chk("clr_frame", 32'(bus.FRAME_ERR), 0);
        run(30);
        chk("stretch_relock", 32'(bus.LOCKED), 1);

        // Phase change 20 -> 5 while locked
        run(16);
        phase_sel = 5;
        run(16);
        chk("chg_old_locked", 32'(bus.LOCKED), 1);
        chk("chg_old_phase",  32'(bus.MEAS_PHASE), 20);
        run(32);
        chk("chg_new_phase",  32'(bus.MEAS_PHASE), 5);
        chk("chg_new_duty",   32'(bus.MEAS_DUTY), 3);
        chk("chg_lock_drop",  32'(bus.LOCKED), 0);
        chk("chg_pair",       32'(bus.PAIR_ERR), 0);
        chk("chg_overlap",    32'(bus.OVERLAP_ERR), 0);
        run(32);
        chk("chg_relock_1", 32'(bus.LOCKED), 0);
        run(32);
        chk("chg_relock_2", 32'(bus.LOCKED), 1);
        chk("chg_relock_phase", 32'(bus.MEAS_PHASE), 5);

        // Reset mid-frame
        run(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_phase",  32'(bus.MEAS_PHASE), 0);
        chk("midrst_duty",   32'(bus.MEAS_DUTY), 0);
        chk("midrst_locked", 32'(bus.LOCKED), 0);
        chk("midrst_valid",  32'(bus.MEAS_VALID), 0);
        do_release();
        vc0 = valid_cnt;
        run(16);
        chk("midrst_no_pub1", 32'(valid_cnt - vc0), 0);
        run(32);
        chk("midrst_pub2",    32'(valid_cnt - vc0), 1);
        chk("midrst_phase2",  32'(bus.MEAS_PHASE), 5);

        // Phase 31, duty 15: MOD rise on MODL rise, MOD/MODN back to back
        rst_n = 1'b0;
        phase_sel = 31;
        duty_sel = 15;
        do_release();
        run(48);
        chk("p31_phase",   32'(bus.MEAS_PHASE), 31);
        chk("p31_duty",    32'(bus.MEAS_DUTY), 15);
        chk("p31_overlap", 32'(bus.OVERLAP_ERR), 0);
        chk("p31_pair",    32'(bus.PAIR_ERR), 0);
        chk("p31_frame",   32'(bus.FRAME_ERR), 0);

        // Phase 2, duty 7: MOD pulse straddles the frame boundary
        rst_n = 1'b0;
        phase_sel = 2;
        duty_sel = 7;
        do_release();
        run(48);
        chk("p2_phase", 32'(bus.MEAS_PHASE), 2);
        chk("p2_duty",  32'(bus.MEAS_DUTY), 7);
        chk("p2_pair",  32'(bus.PAIR_ERR), 0);
        run(32);
        chk("p2_pair_steady",    32'(bus.PAIR_ERR), 0);
        chk("p2_overlap_steady", 32'(bus.OVERLAP_ERR), 0);

        // MODL absent for three frames
        run(16);
        modl_off = 1'b1;
        vc0 = valid_cnt;
        run(96);
        chk("nomodl_no_pub", 32'(valid_cnt - vc0), 0);
        chk("nomodl_frame",  32'(bus.FRAME_ERR), 0);
        modl_off = 1'b0;
        run(16);
        chk("nomodl_return_frame", 32'(bus.FRAME_ERR), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
